spram_fifo_drain: RTL
=====================

Name: spram_fifo_drain

Overview:
- Downstream consumer stage for the single-ported SPRAM FIFO.
- Pops bytes from the FIFO and presents them on a valid/ready stream, e.g. for a UART transmitter or USB serial engine.
- Issues a read only in cycles where the FIFO is not writing, because the single-ported SPRAM cannot read and write together.
- Absorbs the one-cycle SPRAM read latency with a small output buffer, so it never loses or duplicates a byte.

Parameters:
- WIDTH, 8, data width; must match the FIFO data width.
- BUF_DEPTH, 2, output buffer entries; minimum 2, power of two; 2 gives full throughput.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- fifo_data_available  input  1  FIFO not empty
- fifo_write_strobe  input  1  FIFO write in progress this cycle; same signal that drives the FIFO write strobe
- fifo_read_data  input  WIDTH  FIFO read data, valid one cycle after the read was issued
- fifo_read_strobe  output  1  pop request to the FIFO
- out_data  output  WIDTH  stream data
- out_valid  output  1  stream data valid
- out_ready  input  1  downstream accepts out_data this cycle
- busy  output  1  read in flight or buffer non-empty

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset. All registers clear on reset assertion regardless of clk.
- Reset values: fifo_read_strobe=0, out_valid=0, out_data=0, busy=0, buffer count=0, inflight=0.
- Issue rule (combinational): fifo_read_strobe = fifo_data_available & !fifo_write_strobe & (count + inflight - pop < BUF_DEPTH).
  - pop = out_valid & out_ready.
  - count + inflight is never allowed to exceed BUF_DEPTH.
- Pipeline:
  - inflight <= fifo_read_strobe every cycle.
  - If inflight=1, fifo_read_data is written into the buffer tail that cycle, unconditionally, even if fifo_write_strobe=1 in the capture cycle. The SPRAM output register holds the previously read word.
- Read latency: strobe issued in cycle N; byte enters the buffer at the end of N+1; out_valid is asserted in N+2 at the earliest. The output is registered.
- Buffer:
  - Circular, BUF_DEPTH entries, with head/tail pointers of log2(BUF_DEPTH) bits that wrap naturally.
  - out_data = entry at head; out_valid = (count != 0).
  - Simultaneous push and pop: count unchanged, both pointers advance.
- Throughput: 1 byte/cycle sustained while fifo_data_available=1, fifo_write_strobe=0 and out_ready=1.
- Every cycle with fifo_write_strobe=1 suppresses that cycle's issue. Reads resume the next cycle with no other penalty.
- Empty FIFO: no strobe. A strobe is never issued when fifo_data_available=0.
  - The FIFO flag updates one cycle after a pop, so back-to-back strobes are safe.
- Backpressure: with out_ready=0, at most BUF_DEPTH bytes are fetched, then strobing stops.
  - No byte is dropped or reordered; out_data is stable while out_valid=1 and out_ready=0.
- Ordering: bytes appear on out_data in exact FIFO order.
- Reset mid-operation: an in-flight read is discarded and the buffer is emptied. The FIFO is expected to be reset on the same reset, so its pointers re-align.
- busy = inflight | (count != 0).

Decomposition:
- Shared package holds:
  - the FIFO data width constant (8);
  - the SPRAM read-latency constant (1);
  - the log2 helper used for pointer widths.
- One sub-module is natural: stream_skid_buffer, a generic BUF_DEPTH×WIDTH circular buffer with push/pop/count and async reset.
- The drain control (issue rule, inflight) stays in the top module.

Test Plan:
- Reset then load FIFO with 0x41,0x42,0x43, out_ready=1 -> strobes in cycles 0,1,2; out_valid first in cycle 2; out_data 0x41,0x42,0x43 on consecutive cycles; busy=0 afterwards.
- FIFO holding 5 bytes, fifo_write_strobe=1 on cycles 1 and 3 -> strobes only in cycles 0,2,4,5,6; all 5 bytes delivered in order; never a strobe coincident with a write.
- out_ready=0 with 8 bytes available -> exactly 2 strobes, out_valid=1, out_data held at the first byte. Raise out_ready -> remaining 8 bytes delivered in order at 1/cycle.
- Empty FIFO with fifo_data_available=0 for 20 cycles -> fifo_read_strobe never asserts, out_valid=0, busy=0.
- Reset asserted asynchronously mid-cycle while inflight=1 and count=1 -> outputs drop to 0 before the next clk edge; no byte emitted after release until new data arrives.
- Random stimulus, 10,000 bytes with random write strobes and out_ready duty 30% -> scoreboard shows exact in-order match and zero strobes with a write or empty flag active.

Source files
------------

// File: rtl/spram_fifo_drain_pkg.sv
// Shared constants and helpers for the SPRAM FIFO drain stage.
package spram_fifo_drain_pkg;

    localparam int FIFO_WIDTH         = 8;
    localparam int SPRAM_READ_LATENCY = 1;

    // Smallest n with 2**n >= value.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/spram_fifo_drain_stream_skid_buffer.sv
// Circular DEPTH x WIDTH buffer with push/pop/count; absorbs the SPRAM read latency.
module stream_skid_buffer
    import spram_fifo_drain_pkg::*;
#(
    parameter  int WIDTH = FIFO_WIDTH,
    parameter  int DEPTH = 2,
    localparam int PTR_W = log2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // NOTE: the entries are reset too, so the head entry (and out_data) reads 0 after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[tail] <= push_data;
        end
    end

    // NOTE: non-blocking updates keep push and pop in the same cycle order-independent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/spram_fifo_drain.sv
// Drains a single-ported SPRAM FIFO onto a valid/ready byte stream,
// issuing reads only in cycles where the FIFO is not being written.
module spram_fifo_drain
    import spram_fifo_drain_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_data_available,
    input  logic             fifo_write_strobe,
    input  logic [WIDTH-1:0] fifo_read_data,
    output logic             fifo_read_strobe,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CNT_W = log2(BUF_DEPTH) + 1;
    // Headroom for the reads still in flight on top of the buffered count.
    localparam int OCC_W = CNT_W + SPRAM_READ_LATENCY;

    logic             inflight;
    logic             pop;
    logic [CNT_W-1:0] count;
    logic [OCC_W-1:0] occupancy;

    assign pop       = out_valid & out_ready;
    assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);

    // Held low during reset so a FIFO still reporting data cannot be popped.
    assign fifo_read_strobe = ~reset & fifo_data_available & ~fifo_write_strobe
                              & (occupancy < OCC_W'(BUF_DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) inflight <= 1'b0;
        else       inflight <= fifo_read_strobe;
    end

    // The SPRAM output register still holds the read word during a write,
    // so capture is unconditional on inflight.
    stream_skid_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (fifo_read_data),
        .pop       (pop),
        .head_data (out_data),
        .count     (count)
    );

    assign out_valid = (count != '0);
    assign busy      = inflight | out_valid;

endmodule
